store_align_unit: RTL
=====================

Name: store_align_unit

Overview:
- Store-side data narrowing and merge unit for the multicycle MIPS datapath; the inverse of load-side sign/zero extension.
- Accepts SB/SH/SW requests from the control FSM.
- Truncates the 32-bit register operand to byte or halfword and places it in the addressed lane(s).
- Writes a word-only memory; sub-word stores use a read-modify-write sequence.

Parameters:
BIT_WIDTH, 32, data word width (only 32 supported)
ADDR_WIDTH, 32, byte-address width
READ_LATENCY, 1, memory read latency in cycles (legal 1..3)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  store request valid
req_ready  output  1  unit can accept a request
req_addr  input  ADDR_WIDTH  byte address
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_data  input  BIT_WIDTH  register operand; upper bits ignored for SB/SH
done  output  1  one-cycle pulse: store committed
err  output  1  one-cycle pulse: misaligned or illegal request, nothing written
mem_addr  output  ADDR_WIDTH-2  word address
mem_re  output  1  memory read strobe
mem_we  output  1  memory write strobe
mem_wdata  output  BIT_WIDTH  write data
mem_rdata  input  BIT_WIDTH  read data, valid READ_LATENCY cycles after mem_re

Behaviour:
- Interface: single clock clk; synchronous active-low reset rst_n.
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; latched request and wait counter clear.
  - done, err, mem_re and mem_we are 0; mem_addr and mem_wdata are 0.
  - req_ready is 0 while rst_n is low.
- Handshake:
  - req_ready = (state==IDLE) and rst_n.
  - Accept occurs on a cycle T with req_valid and req_ready; addr, size and data are latched at that edge.
  - No new accept until the unit returns to IDLE.
- States: IDLE, ERR, READ, WAIT, WRITE, DONE.
- Decode at accept:
  - ERR if size==11, size==01 with addr[0]==1, or size==10 with addr[1:0]!=0.
  - Otherwise size==10 goes to WRITE; byte and half go to READ.
- ERR: err=1 for one cycle (T+1), then IDLE. No mem_re, no mem_we, no done.
- READ: mem_re=1 for exactly one cycle (T+1), then WAIT. The wait counter loads READ_LATENCY.
- WAIT:
  - Lasts READ_LATENCY cycles (T+2 .. T+1+READ_LATENCY).
  - On the last WAIT cycle, mem_rdata is sampled and the merged word is registered.
  - Byte merge: lane k=addr[1:0] gets bits [8k+7:8k] = data[7:0]; other lanes keep mem_rdata.
  - Half merge: h=addr[1]; bits [16h+15:16h] = data[15:0]; the other half keeps mem_rdata.
- WRITE:
  - mem_we=1 for one cycle.
  - Word store: mem_wdata = latched data.
  - Sub-word store: mem_wdata = merged word.
- DONE: done=1 for one cycle, then IDLE.
- Little-endian lane numbering throughout.
- mem_addr = latched addr[ADDR_WIDTH-1:2], held constant from READ through WRITE; 0 in IDLE/ERR/DONE.
- mem_wdata is 0 except in WRITE.
- Latency from accept T:
  - Word: mem_we at T+1, done at T+2, req_ready at T+3.
  - Sub-word: mem_we at T+2+READ_LATENCY, done at T+3+READ_LATENCY.
- Boundaries:
  - req_valid held high across DONE is not accepted until IDLE.
  - Reset asserted in any state aborts: no further mem_we, done or err. A write already strobed is not retracted.
  - mem_rdata is ignored outside the final WAIT cycle.
  - err and done are never asserted in the same cycle.
  - mem_re and mem_we are never asserted in the same cycle.

Test Plan:
1. Word store: addr 0x100, size 10, data 0xDEADBEEF accepted at T -> mem_we=1 at T+1, mem_addr=0x40, mem_wdata=0xDEADBEEF; done at T+2; no mem_re.
2. Byte store: addr 0x103, data 0x123456AB, memory word 0x11223344, READ_LATENCY=1 -> mem_re at T+1; mem_we at T+3 with mem_wdata=0xAB223344; done at T+4.
3. Half store: addr 0x102, data 0xFFFF8765, old word 0x11223344 -> mem_wdata=0x87653344. Repeat at addr 0x100 -> 0x11228765.
4. Misaligned cases: half at 0x101, word at 0x102, size 11 -> err pulse at T+1, no mem_re/mem_we/done, req_ready high at T+2.
5. READ_LATENCY=3: byte store addr 0x000, data 0x55, old word 0xFFFFFFFF -> mem_we at T+5, wdata=0xFFFFFF55, done at T+6.
6. rst_n driven low during WAIT -> next cycle IDLE with all outputs 0, no mem_we, no done; after release, a word store completes normally.

Source files
------------

// File: rtl/store_align_unit_if.sv
// Store request and word-memory bus bundle for store_align_unit.
// Latency: none, plain wires.
// Backpressure: req_valid/req_ready on the request side. The memory side has no stall.
// Ports: req_valid/req_ready/req_addr/req_size/req_data form the request channel.
//        done/err are the completion pulses.
//        mem_addr/mem_re/mem_we/mem_wdata/mem_rdata form the word-memory port.
interface store_align_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BIT_WIDTH  = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic [BIT_WIDTH-1:0]  req_data;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [BIT_WIDTH-1:0]  mem_wdata;
  logic [BIT_WIDTH-1:0]  mem_rdata;

  // master: requester plus memory model. slave: the store unit.
  modport master (
    output req_valid, req_addr, req_size, req_data, mem_rdata,
    input  req_ready, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_rdata,
    output req_ready, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_align_unit.sv
// Narrows SB/SH/SW operands into their byte lanes and writes a word-only memory, using read-modify-write for sub-word stores.
// Latency from accept T: word mem_we at T+1 and done at T+2; sub-word mem_we at T+2+READ_LATENCY and done one cycle later; err at T+1.
// Backpressure: req_ready is high only in IDLE, so exactly one store is in flight at a time.
// Ports: clk, rst_n (synchronous, active low) and bus (slave modport of store_align_unit_if).
module store_align_unit #(
  parameter int BIT_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1   // legal range is 1..3
) (
  input logic              clk,
  input logic              rst_n,
  store_align_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ERR, READ, WAIT, WRITE, DONE} state_t;

  // Only the fields that the merge needs are kept. The word address lives in
  // mem_addr, and the full word-store operand goes straight into mem_wdata.
  typedef struct packed {
    logic        half;
    logic [1:0]  lane;
    logic [15:0] data;
  } req_t;

  state_t         state;
  req_t           req_q;
  logic [1:0]     wait_cnt;
  logic           accept;
  logic           bad;
  logic [BIT_WIDTH-1:0] merged;

  assign bus.req_ready = (state == IDLE) && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    bad = 1'b0;
    case (bus.req_size)
      2'b01:   bad = bus.req_addr[0];
      2'b10:   bad = |bus.req_addr[1:0];
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end

  // Lane merge: the old word from memory, with the addressed byte or halfword replaced.
  always_comb begin
    merged = bus.mem_rdata;
    if (req_q.half)
      merged[{req_q.lane[1], 4'b0000} +: 16] = req_q.data;
    else
      merged[{req_q.lane, 3'b000} +: 8] = req_q.data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_q         <= '0;
      wait_cnt      <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      // Strobes and write data are single-cycle by default.
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_q <= '{half: bus.req_size[0], lane: bus.req_addr[1:0],
                       data: bus.req_data[15:0]};
            if (bad) begin
              state   <= ERR;
              bus.err <= 1'b1;
            end else if (bus.req_size == 2'b10) begin
              state         <= WRITE;
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= bus.req_data;
              bus.mem_addr  <= bus.req_addr[ADDR_WIDTH-1:2];
            end else begin
              state        <= READ;
              bus.mem_re   <= 1'b1;
              bus.mem_addr <= bus.req_addr[ADDR_WIDTH-1:2];
            end
          end
        end
        ERR: state <= IDLE;
        READ: begin
          state    <= WAIT;
          wait_cnt <= 2'(READ_LATENCY);
        end
        WAIT: begin
          // Read data is only trusted on the final wait cycle.
          if (wait_cnt == 2'd1) begin
            state         <= WRITE;
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= merged;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        WRITE: begin
          state        <= DONE;
          bus.done     <= 1'b1;
          bus.mem_addr <= '0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
